des_iter_sched: RTL and testbench

DES_ITER_SCHED -- requirements
Module: des_iter_sched

---
 rtl/des_pkg.sv | 113 +++++++++++
 rtl/des_key_sched.sv | 60 ++++++
 rtl/des_iter_sched.sv | 111 +++++++++++
 tb/tb_des_iter_sched.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: key-rotation schedule, IP/FP/PC1/PC2 bit tables, FSM state type.
// Tables use the DES numbering: entry i names the source bit (1 = MSB) for output bit i+1.
// Pure constants and functions; no state.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Left-rotation amount applied before each encrypt round 1..16
  localparam logic [1:0] SHIFT [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  // Drops the eight parity bits; result is {C0, D0}
  function automatic logic [55:0] des_pc1(input logic [63:0] k);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] cd);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
    return y;
  endfunction

  // Rotation amount for round r; 0 outside 1..16 so idle indices are harmless
  function automatic logic [1:0] shift_of(input logic [4:0] r);
    if (r >= 5'd1 && r <= 5'd16) return SHIFT[r];
    return 2'd0;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_key_sched.sv
// DES key schedule: C/D registers, per-round rotation and PC2 subkey selection.
// Subkey is combinational from this round's rotated C/D; the rotation is committed on step.
// Encrypt rotates left before every round; decrypt uses C0/D0 for round 1, then rotates right.
module des_key_sched
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [55:0] load_cd,
  input  logic        step,
  input  logic        clear,
  input  logic        decrypt,
  input  logic [4:0]  rnd_num,
  output logic [47:0] subkey
);

  logic [27:0] c;
  logic [27:0] d;
  logic [27:0] c_rot;
  logic [27:0] d_rot;
  logic [1:0]  amt;

  // Rotated C/D for the round currently in the datapath
  always_comb begin
    amt   = 2'd0;
    c_rot = c;
    d_rot = d;
    if (decrypt) begin
      // Decrypt walks the encrypt schedule backwards: round r undoes encrypt shift 18-r
      if (rnd_num >= 5'd2) amt = shift_of(5'd18 - rnd_num);
      c_rot = rotr28(c, amt);
      d_rot = rotr28(d, amt);
    end else begin
      amt   = shift_of(rnd_num);
      c_rot = rotl28(c, amt);
      d_rot = rotl28(d, amt);
    end
  end

  assign subkey = des_pc2({c_rot, d_rot});

  // C/D register: load on accept, advance per round, optional clear on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      c <= '0;
      d <= '0;
    end else if (load) begin
      c <= load_cd[55:28];
      d <= load_cd[27:0];
    end else if (clear) begin
      c <= '0;
      d <= '0;
    end else if (step) begin
      c <= c_rot;
      d <= d_rot;
    end
  end

endmodule

// File: rtl/des_iter_sched.sv
// Iterative DES block scheduler driving a shared external round datapath, one round per cycle.
// Latency ROUNDS+1 cycles accept-to-out_valid; one block per ROUNDS+2 cycles with out_ready high.
// Result held until out_ready; no new request taken while busy. Option: DES_SCHED_ZEROIZE_EN.
module des_iter_sched
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_key,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [63:0] rnd_state,
  output logic [47:0] rnd_key,
  input  logic [63:0] rnd_result,
  output logic        busy
);

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  state_e      fsm;
  logic [63:0] blk;
  logic [4:0]  cnt;
  logic        dec_mode;
  logic        accept;
  logic        handshake;
  logic        ks_clear;

  assign accept    = in_valid && (fsm == ST_IDLE);
  assign handshake = out_ready && (fsm == ST_DONE);

`ifdef DES_SCHED_ZEROIZE_EN
  assign ks_clear = handshake;
`else
  assign ks_clear = 1'b0;
`endif

  des_key_sched u_key_sched (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .load_cd (des_pc1(in_key)),
    .step    (fsm == ST_ROUND),
    .clear   (ks_clear),
    .decrypt (dec_mode),
    .rnd_num (cnt + 5'd1),
    .subkey  (rnd_key)
  );

  assign rnd_state = blk;
  // Undo the last round's swap before the final permutation
  assign out_data  = des_fp({blk[31:0], blk[63:32]});

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= ST_IDLE;
      blk       <= '0;
      cnt       <= '0;
      dec_mode  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (accept) begin
            blk      <= des_ip(in_data);
            cnt      <= '0;
            dec_mode <= in_decrypt;
            fsm      <= ST_ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_ROUND: begin
          blk <= rnd_result;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            fsm       <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (handshake) begin
            fsm       <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef DES_SCHED_ZEROIZE_EN
            blk       <= '0;
`endif
          end
        end
        default: begin
          fsm       <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_iter_sched.sv
// Bench for des_iter_sched: supplies the DES round function (E, S-boxes, P) as the external
// datapath, runs known-answer vectors from a table, and checks results through a scoreboard.
// Covers reset values, latency, output stall, mid-round reset, back-to-back and round trips.
module tb_des_iter_sched;

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  typedef struct {
    logic        dec;
    logic [63:0] key;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [63:0] val;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_decrypt = 1'b0;
  logic [63:0] in_key = '0;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [63:0] rnd_state;
  logic [47:0] rnd_key;
  logic [63:0] rnd_result;
  logic        busy;

  int          compared = 0;
  int          mism = 0;
  int          cyc = 0;
  logic        prev_ov = 1'b0;
  logic [63:0] last_out = '0;
  sb_t         sb_q[$];
  int          acc_q[$];
  vec_t        vecs[8];

  des_iter_sched #(.ROUNDS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_decrypt (in_decrypt),
    .in_key     (in_key),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .rnd_state  (rnd_state),
    .rnd_key    (rnd_key),
    .rnd_result (rnd_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] f;
    logic [5:0]  b;
    int          row;
    int          col;
    e = '0;
    s = '0;
    f = '0;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    x = e ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = x[47-6*i -: 6];
      row = {b[5], b[0]};
      col = b[4:1];
      s[31-4*i -: 4] = 4'(SBOX[i][row*16+col]);
    end
    for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
    return f;
  endfunction

  // External round datapath
  always_comb begin
    rnd_result = {rnd_state[31:0], rnd_state[63:32] ^ f_func(rnd_state[31:0], rnd_key)};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    sb_t e;
    if (out_valid && in_ready) begin
      mism++;
      $display("FAIL ready_valid_overlap: both high at cycle %0d", cyc);
    end
    if (out_valid && !prev_ov && acc_q.size() > 0)
      check("latency", 64'(cyc - acc_q.pop_front()), 64'd17);
    if (out_valid && out_ready) begin
      last_out = out_data;
      if (sb_q.size() == 0) begin
        mism++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", out_data);
      end else begin
        e = sb_q.pop_front();
        if (e.chk) check("out_data", out_data, e.val);
      end
    end
    prev_ov = out_valid;
  end

  // Offer one request (called just after a rising edge); returns the accept cycle
  task automatic send(input logic dec, input logic [63:0] key, input logic [63:0] data,
                      input logic push, input logic chk, input logic [63:0] exp, output int acc);
    int n;
    sb_t e;
    n = 0;
    acc = -1;
    in_valid = 1'b1;
    in_decrypt = dec;
    in_key = key;
    in_data = data;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      mism++;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", n);
    end else begin
      acc = cyc;
      if (push) begin
        e.chk = chk;
        e.val = exp;
        sb_q.push_back(e);
        acc_q.push_back(cyc);
      end
    end
    @(posedge clk); #1;
    // Post-accept input changes must not disturb the running block
    in_valid = 1'b0;
    in_decrypt = ~dec;
    in_key = {$urandom, $urandom};
    in_data = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      mism++;
      $display("FAIL idle_timeout: in_ready 0, required 1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      mism++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    int n;
    logic [63:0] pt;
    logic [63:0] k;
    logic [63:0] ct;

    vecs[0] = '{1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405};
    vecs[1] = '{1'b1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
    vecs[2] = '{1'b0, 64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000};
    vecs[3] = '{1'b1, 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
    vecs[4] = '{1'b0, 64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7};
    vecs[5] = '{1'b1, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
    vecs[6] = '{1'b0, 64'h0101010101010101, 64'h8000000000000000, 64'h95F8A5E5DD31D900};
    vecs[7] = '{1'b1, 64'h0101010101010101, 64'h95F8A5E5DD31D900, 64'h8000000000000000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_rnd_state", rnd_state, 64'd0);
    check("rst_rnd_key", 64'(rnd_key), 64'd0);
    rst = 1'b0;

    // Known-answer table through the scoreboard
    for (int i = 0; i < 8; i++)
      send(vecs[i].dec, vecs[i].key, vecs[i].data, 1'b1, 1'b1, vecs[i].exp, a0);
    drain();

    // Output stall: result held, requests ignored while DONE
    out_ready = 1'b0;
    send(vecs[0].dec, vecs[0].key, vecs[0].data, 1'b1, 1'b1, vecs[0].exp, a0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_data", out_data, vecs[0].exp);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_busy", 64'(busy), 64'd1);
      in_valid = 1'b1;
      in_decrypt = 1'b1;
      in_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
    check("post_hs_out_valid", 64'(out_valid), 64'd0);
    check("post_hs_busy", 64'(busy), 64'd0);
`ifdef DES_SCHED_ZEROIZE_EN
    check("zeroize_rnd_state", rnd_state, 64'd0);
    check("zeroize_rnd_key", 64'(rnd_key), 64'd0);
`else
    check("retain_out_data", out_data, vecs[0].exp);
`endif

    // Reset while round 7 is in the datapath
    send(vecs[2].dec, vecs[2].key, vecs[2].data, 1'b0, 1'b0, 64'd0, a0);
    repeat (6) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rnd_state", rnd_state, 64'd0);
    check("mid_rst_rnd_key", 64'(rnd_key), 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    send(vecs[1].dec, vecs[1].key, vecs[1].data, 1'b1, 1'b1, vecs[1].exp, a0);
    drain();

    // Back-to-back with out_ready high
    send(vecs[0].dec, vecs[0].key, vecs[0].data, 1'b1, 1'b1, vecs[0].exp, a0);
    send(vecs[4].dec, vecs[4].key, vecs[4].data, 1'b1, 1'b1, vecs[4].exp, a1);
    check("b2b_gap", 64'(a1 - a0), 64'd18);
    drain();

    // Random encrypt/decrypt round trips
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom};
      pt = {$urandom, $urandom};
      send(1'b0, k, pt, 1'b1, 1'b0, 64'd0, a0);
      drain();
      ct = last_out;
      send(1'b1, k, ct, 1'b1, 1'b1, pt, a0);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
